// File: rtl/fpg8_pkg.sv
// -----------------------------------------------------------------------------
// fpg8_pkg
// Shared definitions for the fpg8 datapath blocks.
//   WORD_W     : native bus / ALU operand width
//   y_state_e  : occupancy state of the Y operand buffer (EMPTY, ONE, TWO)
// -----------------------------------------------------------------------------
package fpg8_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } y_state_e;

endpackage

// File: rtl/y_operand_buffer.sv
// -----------------------------------------------------------------------------
// y_operand_buffer
// Two-entry operand FIFO between the shared data bus and the ALU Y input.
// Y1 is the head (presented to the ALU), Y2 the tail. Overflow (capture while
// full) and underflow (take while empty) raise a sticky error flag.
//
// Ports:
//   clk        : clock, all state changes on rising edge
//   reset      : asynchronous, active-low reset
//   from_bus   : bus value, captured when Y_in=1
//   Y_in       : capture request
//   Y_take     : ALU consumes head operand
//   Y_clr      : synchronous flush (highest priority), also clears Y_err
//   to_ALU     : head operand, 0 when empty
//   Y_valid    : head operand present
//   Y_full     : both entries occupied
//   Y_err      : sticky overflow/underflow flag
//   REG_OUT_Y1 : raw Y1 register (only with Y_OPERAND_DEBUG_EN defined)
//   REG_OUT_Y2 : raw Y2 register (only with Y_OPERAND_DEBUG_EN defined)
//
// Build option: define Y_OPERAND_DEBUG_EN to expose the raw entry registers.
// -----------------------------------------------------------------------------
module y_operand_buffer
  import fpg8_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] from_bus,
  input  logic             Y_in,
  input  logic             Y_take,
  input  logic             Y_clr,
  output logic [WIDTH-1:0] to_ALU,
  output logic             Y_valid,
  output logic             Y_full,
  output logic             Y_err
`ifdef Y_OPERAND_DEBUG_EN
  ,
  output logic [WIDTH-1:0] REG_OUT_Y1,
  output logic [WIDTH-1:0] REG_OUT_Y2
`endif
);

  y_state_e         state_q, state_d;
  logic [WIDTH-1:0] y1_q, y1_d;
  logic [WIDTH-1:0] y2_q, y2_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      y1_q    <= '0;
      y2_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    err_d   = err_q;
    if (Y_clr) begin
      state_d = EMPTY;
      y1_d    = '0;
      y2_d    = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          // A simultaneous take is satisfied by nothing yet, but the capture
          // still lands; only a lone take is an underflow.
          if (Y_in) begin
            y1_d    = from_bus;
            state_d = ONE;
          end else if (Y_take) begin
            err_d = 1'b1;
          end
        end
        ONE: begin
          if (Y_in && Y_take) begin
            // Head consumed and replaced in the same cycle.
            y1_d = from_bus;
          end else if (Y_in) begin
            y2_d    = from_bus;
            state_d = TWO;
          end else if (Y_take) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (Y_take) begin
            y1_d = y2_q;
            if (Y_in) begin
              y2_d = from_bus;
            end else begin
              state_d = ONE;
            end
          end else if (Y_in) begin
            // Overflow: incoming word is dropped, entries left intact.
            err_d = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Y1 may hold a stale word after draining to EMPTY, so the output is gated
  // by the registered state rather than relying on Y1 being cleared.
  assign Y_valid = (state_q == ONE) || (state_q == TWO);
  assign Y_full  = (state_q == TWO);
  assign to_ALU  = Y_valid ? y1_q : '0;
  assign Y_err   = err_q;

`ifdef Y_OPERAND_DEBUG_EN
  assign REG_OUT_Y1 = y1_q;
  assign REG_OUT_Y2 = y2_q;
`endif

endmodule

// File: tb/tb_y_operand_buffer.sv
// -----------------------------------------------------------------------------
// tb_y_operand_buffer
// Scoreboard bench for y_operand_buffer. The stimulus process updates a
// queue-based reference model and pushes the expected outputs; an independent
// monitor pops and compares one expectation per clock edge.
// -----------------------------------------------------------------------------
module tb_y_operand_buffer;

  logic        clk;
  logic        reset;
  logic [15:0] from_bus;
  logic        Y_in;
  logic        Y_take;
  logic        Y_clr;
  logic [15:0] to_ALU;
  logic        Y_valid;
  logic        Y_full;
  logic        Y_err;
`ifdef Y_OPERAND_DEBUG_EN
  logic [15:0] REG_OUT_Y1;
  logic [15:0] REG_OUT_Y2;
`endif

  y_operand_buffer #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .from_bus (from_bus),
    .Y_in     (Y_in),
    .Y_take   (Y_take),
    .Y_clr    (Y_clr),
    .to_ALU   (to_ALU),
    .Y_valid  (Y_valid),
    .Y_full   (Y_full),
    .Y_err    (Y_err)
`ifdef Y_OPERAND_DEBUG_EN
    ,
    .REG_OUT_Y1 (REG_OUT_Y1),
    .REG_OUT_Y2 (REG_OUT_Y2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] data;
    logic        valid;
    logic        full;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_q[$];   // reference FIFO contents, head at index 0
  logic        model_err;
  int          checks;
  int          failures;
  int          txn;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference behaviour: a bounded two-deep FIFO plus sticky error.
  task automatic model_step(input logic in_v, input logic take_v, input logic clr_v,
                            input logic [15:0] bus);
    if (clr_v) begin
      model_q.delete();
      model_err = 1'b0;
    end else if (in_v && take_v) begin
      if (model_q.size() > 0) void'(model_q.pop_front());
      model_q.push_back(bus);
    end else if (in_v) begin
      if (model_q.size() < 2) model_q.push_back(bus);
      else model_err = 1'b1;
    end else if (take_v) begin
      if (model_q.size() > 0) void'(model_q.pop_front());
      else model_err = 1'b1;
    end
  endtask

  // One clocked transaction: drive at negedge, predict, wait for the edge.
  task automatic cycle(input logic in_v, input logic take_v, input logic clr_v,
                       input logic [15:0] bus);
    exp_t e;
    @(negedge clk);
    Y_in = in_v; Y_take = take_v; Y_clr = clr_v; from_bus = bus;
    model_step(in_v, take_v, clr_v, bus);
    e.idx   = txn;
    e.valid = (model_q.size() > 0);
    e.full  = (model_q.size() == 2);
    e.data  = e.valid ? model_q[0] : 16'h0000;
    e.err   = model_err;
    exp_q.push_back(e);
    $display("txn %0d in=%0b take=%0b clr=%0b bus=%h", txn, in_v, take_v, clr_v, bus);
    txn++;
    @(posedge clk);
    #2;
  endtask

  // Reset asserted between edges, held across one edge with a capture pending.
  task automatic reset_pulse(input logic [15:0] bus);
    @(negedge clk);
    Y_in = 1'b1; Y_take = 1'b0; Y_clr = 1'b0; from_bus = bus;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_to_ALU", to_ALU, 16'h0000);
    chk("async_rst_valid", {15'd0, Y_valid}, 16'h0000);
    chk("async_rst_full", {15'd0, Y_full}, 16'h0000);
    chk("async_rst_err", {15'd0, Y_err}, 16'h0000);
    @(posedge clk);
    #2;
    chk("rst_abort_valid", {15'd0, Y_valid}, 16'h0000);
    @(negedge clk);
    Y_in = 1'b0;
    #1 reset = 1'b1;
    model_q.delete();
    model_err = 1'b0;
  endtask

  // Monitor: compares one expectation at each rising edge that has one.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 4;
        if (to_ALU !== e.data) begin
          failures++;
          $display("FAIL sb_to_ALU txn=%0d actual=%h required=%h", e.idx, to_ALU, e.data);
        end
        if (Y_valid !== e.valid) begin
          failures++;
          $display("FAIL sb_Y_valid txn=%0d actual=%0b required=%0b", e.idx, Y_valid, e.valid);
        end
        if (Y_full !== e.full) begin
          failures++;
          $display("FAIL sb_Y_full txn=%0d actual=%0b required=%0b", e.idx, Y_full, e.full);
        end
        if (Y_err !== e.err) begin
          failures++;
          $display("FAIL sb_Y_err txn=%0d actual=%0b required=%0b", e.idx, Y_err, e.err);
        end
      end
    end
  end

  initial begin
    logic        r_in, r_take, r_clr;
    logic [15:0] r_bus;
    checks = 0; failures = 0; txn = 0;
    model_err = 1'b0;
    reset = 1'b0; Y_in = 1'b0; Y_take = 1'b0; Y_clr = 1'b0; from_bus = 16'h0;
    #12;
    chk("reset_to_ALU", to_ALU, 16'h0000);
    chk("reset_valid", {15'd0, Y_valid}, 16'h0000);
    chk("reset_full", {15'd0, Y_full}, 16'h0000);
    chk("reset_err", {15'd0, Y_err}, 16'h0000);
    @(negedge clk);
    #1 reset = 1'b1;

    // Single capture visible one cycle later.
    cycle(1, 0, 0, 16'h1234);
    chk("cap_to_ALU", to_ALU, 16'h1234);
    chk("cap_full", {15'd0, Y_full}, 16'h0000);
    cycle(0, 1, 0, 16'h0000);

    // Fill to TWO, then drain one.
    cycle(1, 0, 0, 16'hAAAA);
    cycle(1, 0, 0, 16'h5555);
    chk("two_full", {15'd0, Y_full}, 16'h0001);
    chk("two_head", to_ALU, 16'hAAAA);
    cycle(0, 1, 0, 16'h0000);
    chk("take_head", to_ALU, 16'h5555);
    chk("take_full", {15'd0, Y_full}, 16'h0000);

    // Overflow in TWO, then drain to EMPTY with sticky error.
    cycle(1, 0, 0, 16'h1111);
    cycle(1, 0, 0, 16'hBEEF);
    chk("ovf_err", {15'd0, Y_err}, 16'h0001);
    chk("ovf_head", to_ALU, 16'h5555);
    cycle(0, 1, 0, 16'h0000);
    chk("ovf_tail_kept", to_ALU, 16'h1111);
    cycle(0, 1, 0, 16'h0000);
    chk("drain_to_ALU", to_ALU, 16'h0000);
    chk("drain_err_sticky", {15'd0, Y_err}, 16'h0001);
    cycle(0, 0, 1, 16'h0000);

    // Simultaneous capture and take in ONE.
    cycle(1, 0, 0, 16'h0001);
    cycle(1, 1, 0, 16'h0002);
    chk("swap_to_ALU", to_ALU, 16'h0002);
    chk("swap_full", {15'd0, Y_full}, 16'h0000);
    chk("swap_err", {15'd0, Y_err}, 16'h0000);

    // Move to TWO, then asynchronous reset mid-cycle with a capture pending.
    cycle(1, 0, 0, 16'h0003);
    reset_pulse(16'hDEAD);
    cycle(0, 0, 0, 16'h0000);
    chk("post_rst_valid", {15'd0, Y_valid}, 16'h0000);

    // Underflow, then clear beats a simultaneous capture.
    cycle(0, 1, 0, 16'h0000);
    chk("udf_err", {15'd0, Y_err}, 16'h0001);
    cycle(1, 0, 1, 16'h7777);
    chk("clr_err", {15'd0, Y_err}, 16'h0000);
    chk("clr_valid", {15'd0, Y_valid}, 16'h0000);

    // Randomized traffic, occasional flushes.
    for (int i = 0; i < 400; i++) begin
      r_in   = ($urandom_range(0, 99) < 55);
      r_take = ($urandom_range(0, 99) < 45);
      r_clr  = ($urandom_range(0, 31) == 0);
      r_bus  = 16'($urandom);
      cycle(r_in, r_take, r_clr, r_bus);
    end

    @(negedge clk);
    Y_in = 1'b0; Y_take = 1'b0; Y_clr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("sb_drained", 16'(exp_q.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
